// File: rtl/fir_tap_reader.sv
// fir_tap_reader: ring-buffer sample store plus a sequential tap reader.
// Each accepted sample is written into a DEPTH-entry circular buffer, and then
// the history from newest to oldest is streamed out one tap per handshake.
// Tap 0 is loaded straight from in_sample on the accept edge. This bypass is
// needed because the buffer write happens on that same edge.
// Later taps come from a registered read of the buffer. That read is
// prefetched one tap ahead, so it is always ready at the next handshake.
// Optional build macro: FIR_TAP_FILL_MASK_EN. When it is defined, a
// saturating fill counter forces taps that have not been written since
// reset to zero.
`timescale 1ns/1ps

module fir_tap_reader #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WIDTH-1:0]                        in_sample,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [WIDTH-1:0]                        tap_data,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tap_index,
    output logic                                    tap_valid,
    input  logic                                    tap_ready,
    output logic                                    tap_last,
    output logic                                    overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // The pointer arithmetic relies on DEPTH being a power of two, at least 2.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fir_tap_reader: DEPTH must be a power of two and at least 2");
    end

    logic [0:0]       state_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    base_reg;
    logic [AW-1:0]    tap_index_reg;
    logic             tap_valid_reg;
    logic             tap_last_reg;
    logic [WIDTH-1:0] tap_data_reg;
    logic             overrun_reg;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_q;

    logic             accept;
    logic             handshake;
    logic             final_tap;
    logic             advance;
    logic [AW-1:0]    next_index;
    logic [AW-1:0]    base_next;
    logic [AW-1:0]    rd_cnt_next;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] next_data;

`ifdef FIR_TAP_FILL_MASK_EN
    localparam logic [AW:0] FILL_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] FILL_ONE = (AW + 1)'(1);
    logic [AW:0] fill_reg;
`endif

    assign in_ready  = (state_reg == ST_IDLE);
    assign tap_data  = tap_data_reg;
    assign tap_index = tap_index_reg;
    assign tap_valid = tap_valid_reg;
    assign tap_last  = tap_last_reg;
    assign overrun   = overrun_reg;

    // Handshake decode and the read address of the tap after the one being presented.
    always_comb begin
        accept     = (state_reg == ST_IDLE) && in_valid;
        handshake  = tap_valid_reg && tap_ready;
        final_tap  = (tap_index_reg == LAST_IDX);
        advance    = handshake && !final_tap;
        next_index = tap_index_reg + ONE_IDX;
        base_next  = accept ? wr_ptr_reg : base_reg;
        if (accept) begin
            rd_cnt_next = '0;
        end else if (advance) begin
            rd_cnt_next = next_index;
        end else begin
            rd_cnt_next = tap_index_reg;
        end
        rd_addr = base_next - rd_cnt_next - ONE_IDX;
    end

    // Prefetched tap data, zeroed when that tap is older than the fill level.
    always_comb begin
        next_data = mem_q;
`ifdef FIR_TAP_FILL_MASK_EN
        if ({1'b0, next_index} >= fill_reg) begin
            next_data = '0;
        end
`endif
    end

    // Sample buffer: one write port plus a registered read port. It is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= in_sample;
        end
        mem_q <= mem[rd_addr];
    end

    // Two-state sequencer: IDLE waits for a sample, READ streams DEPTH taps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) state_reg <= ST_READ;
                ST_READ: if (handshake && final_tap) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Write pointer and the base of the sequence now being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            base_reg   <= '0;
        end else if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + ONE_IDX;
            base_reg   <= wr_ptr_reg;
        end
    end

    // Tap output registers. Tap 0 bypasses the buffer, and the outputs hold while tap_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_valid_reg <= 1'b0;
            tap_last_reg  <= 1'b0;
            tap_index_reg <= '0;
            tap_data_reg  <= '0;
        end else if (accept) begin
            tap_valid_reg <= 1'b1;
            tap_last_reg  <= 1'b0;
            tap_index_reg <= '0;
            tap_data_reg  <= in_sample;
        end else if (advance) begin
            tap_index_reg <= next_index;
            tap_data_reg  <= next_data;
            tap_last_reg  <= (next_index == LAST_IDX);
        end else if (handshake) begin
            tap_valid_reg <= 1'b0;
            tap_last_reg  <= 1'b0;
        end
    end

    // Sticky overrun: a strobe that arrives while busy is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else if (in_valid && (state_reg != ST_IDLE)) begin
            overrun_reg <= 1'b1;
        end
    end

`ifdef FIR_TAP_FILL_MASK_EN
    // Count accepted samples since reset, saturating at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_reg <= '0;
        end else if (accept && (fill_reg != FILL_MAX)) begin
            fill_reg <= fill_reg + FILL_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_fir_tap_reader.sv
// Testbench for fir_tap_reader. It checks the DUT against a ring-history
// reference model, using a stimulus table plus hand sequences and random traffic.
`timescale 1ns/1ps

module tb_fir_tap_reader;

    localparam int WIDTH = 20;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  in_sample;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  tap_data;
    logic [3:0]        tap_index;
    logic              tap_valid;
    logic              tap_ready;
    logic              tap_last;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    // Reference model. History slots survive reset, but the write position and fill do not.
    logic [WIDTH-1:0] m_hist [DEPTH];
    bit               m_written [DEPTH];
    int               m_wp = 0;
    int               m_base = 0;
    int               m_fill = 0;
    bit               m_ovr = 0;

    typedef struct {
        logic [WIDTH-1:0] sample;
        logic [WIDTH-1:0] exp_first;
        logic [WIDTH-1:0] exp_last;
        bit               last_known;
    } vec_t;

    vec_t tbl [17];

    fir_tap_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tap_data  (tap_data),
        .tap_index (tap_index),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_wp = 0;
        m_base = 0;
        m_fill = 0;
        m_ovr = 0;
    endfunction

    function automatic void model_accept(input logic [WIDTH-1:0] s);
        m_hist[m_wp] = s;
        m_written[m_wp] = 1'b1;
        m_base = m_wp;
        m_wp = (m_wp + 1) % DEPTH;
        if (m_fill < DEPTH) m_fill++;
    endfunction

    // Tap i is the sample written i accepts before the newest one, counting around the ring.
    function automatic void model_tap(input int i, output bit known, output logic [WIDTH-1:0] v);
        int a;
        a = (m_base - i + DEPTH) % DEPTH;
        v = m_hist[a];
        known = m_written[a];
`ifdef FIR_TAP_FILL_MASK_EN
        known = 1'b1;
        if (i >= m_fill) v = '0;
`endif
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_tap_valid", 32'(tap_valid), 32'(0));
        chk("rst_tap_last", 32'(tap_last), 32'(0));
        chk("rst_tap_data", 32'(tap_data), 32'(0));
        chk("rst_tap_index", 32'(tap_index), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_accept(input logic [WIDTH-1:0] s);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_sample = s;
        step();
        in_valid = 1'b0;
        in_sample = '0;
        model_accept(s);
        chk("latency_valid", 32'(tap_valid), 32'(1));
        chk("latency_index", 32'(tap_index), 32'(0));
        chk("latency_data", 32'(tap_data), 32'(s));
        chk("accept_busy", 32'(in_ready), 32'(0));
    endtask

    // Consume one full tap sequence.
    // mode: 0 = ready held high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // ovr: 0 = no stray strobe, 1 = a stray strobe at cycle 3, 2 = random stray strobes.
    task automatic collect(input int mode, input int ovr, output logic [WIDTH-1:0] first_d,
                           output logic [WIDTH-1:0] last_d, output bit saw_ff);
        int hs;
        int cyc;
        bit hold;
        bit known;
        logic [WIDTH-1:0] ev;
        logic [WIDTH-1:0] pd;
        logic [3:0] pi;
        logic pl;
        hs = 0;
        cyc = 0;
        hold = 1'b0;
        pd = '0;
        pi = '0;
        pl = 1'b0;
        first_d = '0;
        last_d = '0;
        saw_ff = 1'b0;
        while (hs < DEPTH && cyc < 400) begin
            chk("tap_valid", 32'(tap_valid), 32'(1));
            chk("busy_in_ready", 32'(in_ready), 32'(0));
            chk("tap_index", 32'(tap_index), 32'(hs));
            chk("tap_last", 32'(tap_last), 32'(hs == DEPTH - 1));
            model_tap(hs, known, ev);
            if (known) chk("tap_data", 32'(tap_data), 32'(ev));
            if (hold) begin
                chk("hold_data", 32'(tap_data), 32'(pd));
                chk("hold_index", 32'(tap_index), 32'(pi));
                chk("hold_last", 32'(tap_last), 32'(pl));
            end
            if (tap_data === 20'hFFFFF) saw_ff = 1'b1;
            if (hs == 0) first_d = tap_data;
            if (hs == DEPTH - 1) last_d = tap_data;
            case (mode)
                0: tap_ready = 1'b1;
                1: tap_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: tap_ready = ($urandom_range(0, 3) != 0);
            endcase
            hold = !tap_ready;
            if (tap_ready) hs++;
            pd = tap_data;
            pi = tap_index;
            pl = tap_last;
            if ((ovr == 1 && cyc == 3) || (ovr == 2 && $urandom_range(0, 19) == 0)) begin
                in_valid = 1'b1;
                in_sample = 20'hFFFFF;
                m_ovr = 1'b1;
            end
            step();
            in_valid = 1'b0;
            in_sample = '0;
            cyc++;
        end
        if (hs < DEPTH) chk("seq_timeout", 32'(hs), 32'(DEPTH));
        chk("end_tap_valid", 32'(tap_valid), 32'(0));
        chk("end_in_ready", 32'(in_ready), 32'(1));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] fd;
        logic [WIDTH-1:0] ld;
        logic [WIDTH-1:0] s;
        bit sf;
        int nv;

        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        tap_ready = 1'b0;

        // Stimulus table for the full-history run: 17 samples wrap the 16-entry ring.
        for (int j = 0; j < 17; j++) begin
            tbl[j].sample     = 20'(j + 1);
            tbl[j].exp_first  = 20'(j + 1);
            tbl[j].exp_last   = (j >= DEPTH - 1) ? 20'(j + 2 - DEPTH) : 20'h0;
`ifdef FIR_TAP_FILL_MASK_EN
            tbl[j].last_known = 1'b1;
`else
            tbl[j].last_known = (j >= DEPTH - 1);
`endif
        end

        apply_reset();

        for (int j = 0; j < 17; j++) begin
            do_accept(tbl[j].sample);
            collect(0, 0, fd, ld, sf);
            chk("tbl_first", 32'(fd), 32'(tbl[j].exp_first));
            if (tbl[j].last_known) chk("tbl_last", 32'(ld), 32'(tbl[j].exp_last));
            $display("seq %0d: sample %h first %h last %h", j, tbl[j].sample, fd, ld);
        end

        // Fill behaviour right after reset.
        apply_reset();
        do_accept(20'h00001);
        collect(0, 0, fd, ld, sf);
        chk("fill_first", 32'(fd), 32'h1);
`ifdef FIR_TAP_FILL_MASK_EN
        chk("fill_last_masked", 32'(ld), 32'h0);
`endif
        $display("fill: first %h last %h", fd, ld);

        // Back-pressure with the ready pattern 1,0,0,1.
        do_accept(20'h5A5A5);
        collect(1, 0, fd, ld, sf);
        $display("backpressure: first %h last %h", fd, ld);

        // A stray strobe during READ must be dropped, and the flag must stay set.
        do_accept(20'h0ABCD);
        collect(0, 1, fd, ld, sf);
        do_accept(20'h00042);
        collect(0, 0, fd, ld, sf);
        chk("ovr_not_stored", 32'(sf), 32'(0));
        chk("ovr_sticky", 32'(overrun), 32'(1));
        $display("overrun: flag %0d saw_dropped %0d", overrun, sf);

        // Throughput with a strobe every 17 cycles: no overrun, 16 valid cycles per period.
        apply_reset();
        tap_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 68; c++) begin
            if (tap_valid === 1'b1) nv++;
            if ((c % 17) == 0) begin
                s = 20'($urandom);
                in_valid = 1'b1;
                in_sample = s;
                model_accept(s);
            end
            step();
            in_valid = 1'b0;
        end
        chk("tput17_duty", 32'(nv), 32'(64));
        chk("tput17_overrun", 32'(overrun), 32'(0));
        chk("tput17_idle", 32'(in_ready), 32'(1));
        $display("throughput17: valid cycles %0d overrun %0d", nv, overrun);

        // A strobe every 16 cycles lands on the final handshake and counts as an overrun.
        for (int c = 0; c < 17; c++) begin
            if (c == 16) chk("tput16_pre", 32'(overrun), 32'(0));
            if (c == 0 || c == 16) begin
                s = 20'($urandom);
                in_valid = 1'b1;
                in_sample = s;
                if (c == 0) model_accept(s);
            end
            step();
            in_valid = 1'b0;
        end
        m_ovr = 1'b1;
        chk("tput16_overrun", 32'(overrun), 32'(1));
        chk("tput16_idle", 32'(in_ready), 32'(1));
        $display("throughput16: overrun %0d", overrun);

        // Reset in the middle of READ aborts the sequence and clears the overrun flag.
        do_accept(20'h12345);
        tap_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) in_valid = 1'b1;
            step();
            in_valid = 1'b0;
        end
        chk("midread_valid", 32'(tap_valid), 32'(1));
        chk("midread_index", 32'(tap_index), 32'(5));
        apply_reset();
        step();
        chk("post_rst_valid", 32'(tap_valid), 32'(0));
        chk("post_rst_ready", 32'(in_ready), 32'(1));
        chk("post_rst_last", 32'(tap_last), 32'(0));
        do_accept(20'h00777);
        collect(0, 0, fd, ld, sf);
        $display("reset_midread: first %h last %h", fd, ld);

        // Random traffic against the model.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 7) == 0) apply_reset();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                chk("gap_ready", 32'(in_ready), 32'(1));
                chk("gap_valid", 32'(tap_valid), 32'(0));
                step();
            end
            s = 20'($urandom);
            do_accept(s);
            collect(2, 2, fd, ld, sf);
            $display("rand %0d: sample %h first %h last %h overrun %0d", r, s, fd, ld, overrun);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
